// File: rtl/softreg_axil_bridge.sv
// SoftReg-to-AXI4-Lite master bridge for an HLS s_axi_control slave.
// One ordered request FIFO feeds one AXI-Lite transaction at a time, with sticky status flags.
module softreg_axil_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LOG_DEPTH  = 2,
  parameter int ADDR_SHIFT = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sr_req_valid,
  input  logic                sr_req_iswrite,
  input  logic [31:0]         sr_req_addr,
  input  logic [DATA_W-1:0]   sr_req_data,
  output logic                sr_resp_valid,
  output logic [DATA_W-1:0]   sr_resp_data,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                status_clr,
  output logic                status_err,
  output logic                status_timeout,
  output logic                status_overflow,
  output logic [15:0]         drop_cnt,
  output logic                busy
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int CW    = LOG_DEPTH + 1;
  localparam int EW    = (ADDR_W > 32 ? ADDR_W : 32) + ADDR_SHIFT;
  localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_B, S_RD_AR, S_RD_R
  } state_t;

  state_t state_q, state_d;

  logic              fifo_w_q [DEPTH];
  logic [31:0]       fifo_a_q [DEPTH];
  logic [DATA_W-1:0] fifo_d_q [DEPTH];

  logic [LOG_DEPTH-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic                 resp_v_q, resp_v_d;
  logic [DATA_W-1:0]    resp_d_q, resp_d_d;
  logic                 err_q, err_d;
  logic                 to_q, to_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          drop_q, drop_d;
  logic [TW-1:0]        wait_q, wait_d;

  logic pop, push, drop;
  logic aw_fire, w_fire;
  logic err_set, to_set;
  logic [EW-1:0] head_ext;
  logic [15:0]   drop_base;

  assign pop      = (state_q == S_IDLE) && (cnt_q != '0);
  assign push     = sr_req_valid && ((cnt_q != CW'(DEPTH)) || pop);
  assign drop     = sr_req_valid && !push;
  assign aw_fire  = m_awvalid && m_awready;
  assign w_fire   = m_wvalid && m_wready;
  assign head_ext = EW'(fifo_a_q[rp_q]) << ADDR_SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      resp_v_q  <= 1'b0;
      resp_d_q  <= '0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
      wait_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_w_q[i] <= 1'b0;
        fifo_a_q[i] <= '0;
        fifo_d_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      resp_v_q  <= resp_v_d;
      resp_d_q  <= resp_d_d;
      err_q     <= err_d;
      to_q      <= to_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      wait_q    <= wait_d;
      if (push) begin
        fifo_w_q[wp_q] <= sr_req_iswrite;
        fifo_a_q[wp_q] <= sr_req_addr;
        fifo_d_q[wp_q] <= sr_req_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pop) state_d = fifo_w_q[rp_q] ? S_WR : S_RD_AR;
      S_WR:    if ((aw_done_q || aw_fire) && (w_done_q || w_fire))
                 state_d = S_WR_B;
      S_WR_B:  if (m_bvalid) state_d = S_IDLE;
      S_RD_AR: if (m_arready) state_d = S_RD_R;
      S_RD_R:  if (m_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_awvalid = (state_q == S_WR) && !aw_done_q;
    m_wvalid  = (state_q == S_WR) && !w_done_q;
    m_wstrb   = m_wvalid ? '1 : '0;
    m_bready  = (state_q == S_WR_B);
    m_arvalid = (state_q == S_RD_AR);
    m_rready  = (state_q == S_RD_R);
    m_awaddr  = addr_q;
    m_araddr  = addr_q;
    m_wdata   = wdata_q;
  end

  always_comb begin
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    rp_d  = pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;

    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (pop) begin
      addr_d  = head_ext[ADDR_W-1:0];
      wdata_d = fifo_d_q[rp_q];
    end

    // Handshake flags live only while in WR so the next write starts clean.
    aw_done_d = (state_d == S_WR) && (aw_done_q || aw_fire);
    w_done_d  = (state_d == S_WR) && (w_done_q || w_fire);

    resp_v_d = (state_q == S_RD_R) && m_rvalid;
    resp_d_d = resp_v_d ? m_rdata : resp_d_q;

    wait_d = wait_q;
    if (state_d != state_q) wait_d = '0;
    else if (state_q != S_IDLE && int'(wait_q) < TIMEOUT)
      wait_d = wait_q + TW'(1);

    err_set = ((state_q == S_WR_B) && m_bvalid && (m_bresp != 2'b00)) ||
              ((state_q == S_RD_R) && m_rvalid && (m_rresp != 2'b00));
    to_set  = (TIMEOUT != 0) && (state_q != S_IDLE) &&
              (state_d == state_q) && (int'(wait_q) == TIMEOUT - 1);

    err_d = (status_clr ? 1'b0 : err_q) || err_set;
    to_d  = (status_clr ? 1'b0 : to_q) || to_set;
    ovf_d = (status_clr ? 1'b0 : ovf_q) || drop;

    drop_base = status_clr ? 16'h0 : drop_q;
    drop_d    = (drop && drop_base != 16'hFFFF) ? drop_base + 16'h1 : drop_base;
  end

  assign sr_resp_valid   = resp_v_q;
  assign sr_resp_data    = resp_d_q;
  assign status_err      = err_q;
  assign status_timeout  = to_q;
  assign status_overflow = ovf_q;
  assign drop_cnt        = drop_q;
  assign busy            = (cnt_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_softreg_axil_bridge.sv
// Scoreboard bench for softreg_axil_bridge with a small AXI-Lite slave model.
// Expected AXI transactions and read data are queued as SoftReg requests are driven.
module tb_softreg_axil_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sr_req_valid, sr_req_iswrite;
  logic [31:0] sr_req_addr;
  logic [63:0] sr_req_data;
  logic        sr_resp_valid;
  logic [63:0] sr_resp_data;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic        m_wvalid, m_wready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic        m_rvalid, m_rready;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        status_clr, status_err, status_timeout, status_overflow;
  logic [15:0] drop_cnt;
  logic        busy;

  softreg_axil_bridge #(
    .ADDR_W(32), .DATA_W(64), .LOG_DEPTH(2), .ADDR_SHIFT(0), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .sr_req_valid(sr_req_valid), .sr_req_iswrite(sr_req_iswrite),
    .sr_req_addr(sr_req_addr), .sr_req_data(sr_req_data),
    .sr_resp_valid(sr_resp_valid), .sr_resp_data(sr_resp_data),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp),
    .status_clr(status_clr), .status_err(status_err),
    .status_timeout(status_timeout), .status_overflow(status_overflow),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [63:0] d;
  } txn_t;

  txn_t        axq[$];
  logic [63:0] rq[$];
  logic [63:0] ref_mem[logic [31:0]];
  logic [63:0] slv_mem[logic [31:0]];

  int n_chk = 0, n_pass = 0;
  int n_resp = 0, n_w = 0, n_wr_exp = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_k = 2'b00, rresp_k = 2'b00;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic sr_send(input logic w, input logic [31:0] a,
                         input logic [63:0] d, input bit dropped);
    txn_t t;
    @(posedge clk); #1;
    sr_req_valid   = 1'b1;
    sr_req_iswrite = w;
    sr_req_addr    = a;
    sr_req_data    = d;
    if (!dropped) begin
      t.w = w; t.a = a; t.d = w ? d : 64'h0;
      axq.push_back(t);
      if (w) begin
        ref_mem[a] = d;
        n_wr_exp++;
      end else begin
        rq.push_back(ref_mem.exists(a) ? ref_mem[a] : 64'hCAFE);
      end
    end
  endtask

  task automatic sr_stop();
    @(posedge clk); #1;
    sr_req_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1; status_clr = 1'b1;
    @(posedge clk); #1; status_clr = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_wait", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  // AXI-Lite slave: fires are sampled at negedge, responses change just after posedge.
  initial begin
    logic aw_f, w_f, b_f, ar_f, r_f;
    logic got_aw, got_w, r_pend;
    logic [31:0] aw_a, ar_a;
    logic [63:0] w_d;
    logic [7:0]  w_s;
    int aw_c, w_c, ar_c, r_c;
    txn_t t;
    got_aw = 0; got_w = 0; r_pend = 0;
    aw_c = 0; w_c = 0; ar_c = 0; r_c = 0;
    aw_a = '0; ar_a = '0; w_d = '0; w_s = '0;
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    forever begin
      @(negedge clk);
      aw_f = m_awvalid & m_awready;
      w_f  = m_wvalid & m_wready;
      b_f  = m_bvalid & m_bready;
      ar_f = m_arvalid & m_arready;
      r_f  = m_rvalid & m_rready;
      if (aw_f) begin got_aw = 1; aw_a = m_awaddr; end
      if (w_f) begin got_w = 1; w_d = m_wdata; w_s = m_wstrb; n_w++; end
      if (ar_f) ar_a = m_araddr;
      @(posedge clk); #1;
      if (rst) begin
        got_aw = 0; got_w = 0; r_pend = 0;
        aw_c = 0; w_c = 0; ar_c = 0; r_c = 0;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_rvalid = 0;
        continue;
      end
      if (b_f) m_bvalid = 0;
      if (r_f) m_rvalid = 0;
      if (got_aw && got_w) begin
        got_aw = 0; got_w = 0;
        if (axq.size() == 0) chk("axi_extra_wr", 1, 0);
        else begin
          t = axq.pop_front();
          chk("wr_kind", 1, t.w);
          chk("awaddr", aw_a, t.a);
          chk("wdata", w_d, t.d);
          chk("wstrb", w_s, 8'hFF);
        end
        slv_mem[aw_a] = w_d;
        m_bvalid = 1; m_bresp = bresp_k;
      end
      if (ar_f) begin
        if (axq.size() == 0) chk("axi_extra_rd", 1, 0);
        else begin
          t = axq.pop_front();
          chk("rd_kind", 0, t.w);
          chk("araddr", ar_a, t.a);
        end
        r_pend = 1; r_c = 0;
      end
      if (r_pend) begin
        if (r_c >= r_dly) begin
          r_pend = 0; m_rvalid = 1; m_rresp = rresp_k;
          m_rdata = slv_mem.exists(ar_a) ? slv_mem[ar_a] : 64'hCAFE;
        end else r_c++;
      end
      aw_c = m_awvalid ? aw_c + 1 : 0;
      w_c  = m_wvalid ? w_c + 1 : 0;
      ar_c = m_arvalid ? ar_c + 1 : 0;
      m_awready = m_awvalid && aw_c > aw_dly;
      m_wready  = m_wvalid && w_c > w_dly;
      m_arready = m_arvalid && ar_c > ar_dly;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && sr_resp_valid) begin
        n_resp++;
        if (rq.size() == 0) chk("resp_extra", 1, 0);
        else chk("rdata", sr_resp_data, rq.pop_front());
      end
    end
  end

  initial begin
    int r0, w0;
    bit seen;
    rst = 1; sr_req_valid = 0; sr_req_iswrite = 0;
    sr_req_addr = 0; sr_req_data = 0; status_clr = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ctrl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                     sr_resp_valid, busy, status_err, status_timeout,
                     status_overflow}, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_wstrb", m_wstrb, 0);

    // single write, latency to valid
    sr_send(1, 32'h10, 64'h1, 0);
    sr_stop();
    @(negedge clk);
    chk("aw_n1", {m_awvalid, m_wvalid}, 2'b00);
    @(negedge clk);
    chk("aw_n2", {m_awvalid, m_wvalid}, 2'b11);
    wait_idle();
    chk("wr_busy", busy, 0);

    // read with delayed data
    r_dly = 3; r0 = n_resp;
    sr_send(0, 32'h18, 0, 0);
    sr_stop();
    wait_idle();
    chk("rd_resp_cnt", n_resp - r0, 1);
    r_dly = 0;

    // burst keeps order
    r0 = n_resp;
    sr_send(1, 32'h20, 64'h1111, 0);
    sr_send(0, 32'h20, 0, 0);
    sr_send(1, 32'h28, 64'h2222, 0);
    sr_stop();
    wait_idle();
    chk("burst_resp_cnt", n_resp - r0, 1);

    // flood with AW blocked
    clr_pulse();
    aw_dly = 1000;
    for (int i = 0; i < 6; i++)
      sr_send(1, 32'h40 + 32'(i * 8), 64'h100 + 64'(i), i == 5);
    sr_stop();
    @(negedge clk);
    chk("flood_ovf", status_overflow, 1);
    chk("flood_drop", drop_cnt, 1);
    aw_dly = 0;
    wait_idle();

    // skewed AW/W with BRESP error
    clr_pulse();
    aw_dly = 5; w_dly = 0; bresp_k = 2'b10; w0 = n_w;
    sr_send(1, 32'h50, 64'hDEAD_BEEF, 0);
    sr_stop();
    wait_idle();
    chk("skew_w_once", n_w - w0, 1);
    chk("bresp_err", status_err, 1);
    aw_dly = 0; bresp_k = 2'b00;
    clr_pulse();
    @(negedge clk);
    chk("clr_flags", {status_err, status_timeout, status_overflow}, 0);
    chk("clr_drop", drop_cnt, 0);

    // RRESP error still returns data
    rresp_k = 2'b10;
    sr_send(0, 32'h50, 0, 0);
    sr_stop();
    wait_idle();
    chk("rresp_err", status_err, 1);
    rresp_k = 2'b00;
    clr_pulse();

    // timeout while ARREADY held low
    ar_dly = 20;
    sr_send(0, 32'h28, 0, 0);
    sr_stop();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_arvalid) begin seen = 1; break; end
    end
    chk("to_arvalid", seen, 1);
    repeat (3) @(negedge clk);
    chk("to_early", status_timeout, 0);
    repeat (12) @(negedge clk);
    chk("to_set", status_timeout, 1);
    chk("to_still_ar", m_arvalid, 1);
    wait_idle();
    ar_dly = 0;

    chk("sb_axi_empty", axq.size(), 0);
    chk("sb_resp_empty", rq.size(), 0);
    chk("w_total", n_w, n_wr_exp);

    // reset while waiting in RD_R
    r_dly = 10;
    sr_send(0, 32'h60, 0, 0);
    sr_stop();
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_rready) begin seen = 1; break; end
    end
    chk("rr_reached", seen, 1);
    #2 rst = 1;
    #1;
    chk("arst_ctrl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                      sr_resp_valid, busy, status_err, status_timeout,
                      status_overflow}, 0);
    chk("arst_addr", {m_araddr, m_awaddr}, 0);
    rq.delete();
    r_dly = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", {busy, sr_resp_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
